// File: rtl/cache_addr_pkg.sv
// cache_addr_pkg: address-split geometry, line/beat types and sequencer state shared by the line address sequencer.
package cache_addr_pkg;
    localparam int I_SIZE     = 64;
    localparam int D_SIZE     = 6;
    localparam int C_SIZE     = 14;
    localparam int A_SIZE     = 8;
    localparam int BEAT_BYTES = 8;
    localparam int IDX_W      = C_SIZE - $clog2(A_SIZE) - D_SIZE;
    localparam int TAG_W      = I_SIZE - IDX_W - D_SIZE;
    localparam int BEATS      = 2**D_SIZE / BEAT_BYTES;
    localparam int BEAT_W     = $clog2(BEATS);
    localparam int OFF_W      = $clog2(BEAT_BYTES);

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [IDX_W-1:0]  index_t;
    typedef logic [D_SIZE-1:0] offset_t;
    typedef logic [BEAT_W-1:0] beat_t;
    typedef logic [I_SIZE-1:0] addr_t;

    typedef enum logic {IDLE, BURST} seq_state_t;

    function automatic addr_t line_addr(tag_t tag, index_t idx, beat_t beat);
        return {tag, idx, beat, {OFF_W{1'b0}}};
    endfunction
endpackage

// File: rtl/line_addr_sequencer_if.sv
// line_addr_sequencer_if: request side (line tag/index) and memory beat side of the line address sequencer.
interface line_addr_sequencer_if;
    import cache_addr_pkg::*;
    logic    req_valid;
    logic    req_ready;
    tag_t    req_tag;
    index_t  req_index;
    logic    req_write;
    offset_t req_offset;
    logic    mem_valid;
    logic    mem_ready;
    addr_t   mem_addr;
    logic    mem_write;
    logic    mem_last;
    logic    done;

    modport master (
        output req_valid, req_tag, req_index, req_write, req_offset, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_write, mem_last, done
    );
    modport slave (
        input  req_valid, req_tag, req_index, req_write, req_offset, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_write, mem_last, done
    );
endinterface

// File: rtl/line_beat_counter.sv
// line_beat_counter: loadable modulo-BEATS beat position plus issued-beat count flagging the final beat.
module line_beat_counter
    import cache_addr_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  step,
    input  beat_t start,
    output beat_t beat,
    output logic  last
);
    beat_t cnt;

    // beat wraps naturally because BEATS is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            beat <= '0;
            cnt  <= '0;
        end else if (load) begin
            beat <= start;
            cnt  <= '0;
        end else if (step) begin
            beat <= beat + 1'b1;
            cnt  <= cnt + 1'b1;
        end
    end

    assign last = cnt == beat_t'(BEATS - 1);
endmodule

// File: rtl/line_addr_sequencer.sv
// line_addr_sequencer: rebuilds {tag, index, beat} byte addresses for a line burst, one beat per handshake.
// Optional CRITICAL_WORD_FIRST_EN: fills start at the beat holding req_offset and wrap.
module line_addr_sequencer
    import cache_addr_pkg::*;
(
    input logic clk,
    input logic rst,
    line_addr_sequencer_if.slave bus
);
    seq_state_t state;
    tag_t       tag_q;
    index_t     idx_q;
    beat_t      start;
    beat_t      beat;
    logic       last;
    logic       accept;
    logic       fire;

    assign accept = bus.req_valid && bus.req_ready;
    assign fire   = bus.mem_valid && bus.mem_ready;

`ifdef CRITICAL_WORD_FIRST_EN
    assign start = bus.req_write ? '0 : bus.req_offset[D_SIZE-1:OFF_W];
`else
    logic unused_offset;
    assign unused_offset = ^bus.req_offset;
    assign start = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tag_q         <= '0;
            idx_q         <= '0;
            bus.mem_write <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= fire && last;
            if (accept) begin
                state         <= BURST;
                tag_q         <= bus.req_tag;
                idx_q         <= bus.req_index;
                bus.mem_write <= bus.req_write;
            end else if (fire && last) begin
                state <= IDLE;
            end
        end
    end

    line_beat_counter u_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .step  (fire),
        .start (start),
        .beat  (beat),
        .last  (last)
    );

    // ready is held low for the whole reset so no request slips in alongside it
    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.mem_valid = state == BURST;
    assign bus.mem_last  = bus.mem_valid && last;
    assign bus.mem_addr  = line_addr(tag_q, idx_q, beat);
endmodule

// File: tb/tb_line_addr_sequencer.sv
// tb_line_addr_sequencer: directed and random bursts checked against a queue-of-addresses reference model.
module tb_line_addr_sequencer;
    import cache_addr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    line_addr_sequencer_if bus ();

    line_addr_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [63:0] exp_q[$];
    logic        exp_done = 1'b0;
    logic        exp_write = 1'b0;
    logic [63:0] exp_tag = '0;
    logic [63:0] exp_idx = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic void push_burst(input logic [63:0] t, input int ix, input logic wr, input int off);
        int s;
        s = 0;
`ifdef CRITICAL_WORD_FIRST_EN
        if (!wr) s = (off % (2**D_SIZE)) / BEAT_BYTES;
`endif
        exp_tag   = t & ((64'd1 << TAG_W) - 1);
        exp_idx   = 64'(ix % (2**IDX_W));
        exp_write = wr;
        exp_q.delete();
        for (int k = 0; k < BEATS; k++)
            exp_q.push_back((exp_tag << (IDX_W + D_SIZE)) + (exp_idx << D_SIZE) + 64'(((s + k) % BEATS) * BEAT_BYTES));
    endfunction

    task automatic check_outputs();
        chk("mem_valid", 64'(bus.mem_valid), 64'(exp_q.size() != 0));
        chk("req_ready", 64'(bus.req_ready), 64'(exp_q.size() == 0));
        chk("done", 64'(bus.done), 64'(exp_done));
        if (exp_q.size() != 0) begin
            chk("mem_addr", bus.mem_addr, exp_q[0]);
            chk("mem_last", 64'(bus.mem_last), 64'(exp_q.size() == 1));
            chk("mem_write", 64'(bus.mem_write), 64'(exp_write));
            chk("split_tag", bus.mem_addr >> (IDX_W + D_SIZE), exp_tag);
            chk("split_idx", (bus.mem_addr >> D_SIZE) % (2**IDX_W), exp_idx);
        end else begin
            chk("mem_last_idle", 64'(bus.mem_last), 64'd0);
        end
    endtask

    task automatic step(input logic rv, input logic [63:0] t, input int ix, input logic wr, input int off, input logic mr);
        logic v;
        v = exp_q.size() != 0;
        bus.req_valid  = rv;
        bus.req_tag    = tag_t'(t);
        bus.req_index  = index_t'(ix);
        bus.req_write  = wr;
        bus.req_offset = offset_t'(off);
        bus.mem_ready  = mr;
        exp_done = v && mr && exp_q.size() == 1;
        if (v) begin
            if (mr) void'(exp_q.pop_front());
        end else if (rv) begin
            push_burst(t, ix, wr, off);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_done  = 1'b0;
        exp_write = 1'b0;
        chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        chk("rst_mem_last", 64'(bus.mem_last), 64'd0);
        chk("rst_mem_write", 64'(bus.mem_write), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 64'd0, 0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_tag    = '0;
        bus.req_index  = '0;
        bus.req_write  = 1'b0;
        bus.req_offset = '0;
        bus.mem_ready  = 1'b0;
        do_reset();
        do_reset();

        // full-speed writeback
        step(1'b1, 64'd1, 3, 1'b1, 0, 1'b1);
        idle(10);
        // stalled writeback, ready toggling
        step(1'b1, 64'd1, 3, 1'b1, 0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 64'd0, 0, 1'b0, 0, 1'(i % 2));
        idle(3);
        // fill with offset 0x2C
        step(1'b1, 64'd1, 3, 1'b0, 'h2C, 1'b1);
        idle(10);
        // reset after third beat accepted
        step(1'b1, 64'd5, 7, 1'b0, 'h17, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 0, 1'b0, 0, 1'b1);
        do_reset();
        step(1'b1, 64'd9, 2, 1'b1, 'h3F, 1'b1);
        idle(10);
        // request held through the done cycle
        for (int i = 0; i < 20; i++) step(1'b1, 64'(i / 9 + 2), 4, 1'b0, 'h08, 1'b1);
        idle(3);
        // all-ones tag and index
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 'h1F, 1'b1, 0, 1'b1);
        idle(10);
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 'h1F, 1'b0, 'h3F, 1'b1);
        idle(10);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(1'($urandom_range(0, 2) == 0), {32'($urandom), 32'($urandom)},
                      int'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 63)),
                      1'($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
